// File: rtl/dsp_ctrl_decode.sv
// Issue-side decoder producing the registered DSP48E1 control bundle
// (OPMODE/ALUMODE/CE*) for EXE2, including the multi-beat MACN sequencer.
module dsp_ctrl_decode #(
    parameter int unsigned OPC_W = 5,
    parameter int unsigned CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             INSTR_VALID,
    output logic             INSTR_READY,
    input  logic [OPC_W-1:0] INSTR_OPC,
    input  logic [CNT_W-1:0] INSTR_CNT,
    input  logic             STALL,
    output logic [6:0]       OPMODE,
    output logic [3:0]       ALUMODE,
    output logic             CEA2,
    output logic             CEB2,
    output logic             CEC,
    output logic             CEM,
    output logic             OUT_VALID,
    output logic             ILLEGAL,
    output logic             BUSY
);

    typedef enum logic {
        S_IDLE,
        S_SEQ
    } state_e;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP  = OPC_W'(0),
        OP_ADD  = OPC_W'(1),
        OP_SUB  = OPC_W'(2),
        OP_MUL  = OPC_W'(3),
        OP_MAC  = OPC_W'(4),
        OP_MACN = OPC_W'(5)
    } opc_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [6:0]       opmode_q, opmode_d;
    logic [3:0]       alumode_q, alumode_d;
    logic [3:0]       ce_q, ce_d;
    logic             valid_q, valid_d;
    logic             illegal_q, illegal_d;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= S_IDLE;
            rem_q     <= '0;
            opmode_q  <= '0;
            alumode_q <= '0;
            ce_q      <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            opmode_q  <= opmode_d;
            alumode_q <= alumode_d;
            ce_q      <= ce_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
        end
    end

    // Everything holds under STALL; only the ILLEGAL pulse is cleared.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        opmode_d  = opmode_q;
        alumode_d = alumode_q;
        ce_d      = ce_q;
        valid_d   = valid_q;
        illegal_d = 1'b0;
        if (!STALL) begin
            case (state_q)
                S_IDLE: begin
                    opmode_d  = '0;
                    alumode_d = '0;
                    ce_d      = '0;
                    valid_d   = 1'b0;
                    if (INSTR_VALID) begin
                        case (INSTR_OPC)
                            OP_NOP: ;
                            OP_ADD: begin
                                opmode_d = 7'h33;
                                ce_d     = 4'b1110;
                                valid_d  = 1'b1;
                            end
                            OP_SUB: begin
                                opmode_d  = 7'h33;
                                alumode_d = 4'b0011;
                                ce_d      = 4'b1110;
                                valid_d   = 1'b1;
                            end
                            OP_MUL: begin
                                opmode_d = 7'h05;
                                ce_d     = 4'b1101;
                                valid_d  = 1'b1;
                            end
                            OP_MAC: begin
                                opmode_d = 7'h25;
                                ce_d     = 4'b1101;
                                valid_d  = 1'b1;
                            end
                            OP_MACN: begin
                                opmode_d = 7'h05;
                                ce_d     = 4'b1101;
                                valid_d  = 1'b1;
                                // N of 0 or 1 is a plain single-beat multiply.
                                if (INSTR_CNT > CNT_W'(1)) begin
                                    rem_d   = INSTR_CNT - CNT_W'(1);
                                    state_d = S_SEQ;
                                end
                            end
                            default: illegal_d = 1'b1;
                        endcase
                    end
                end
                S_SEQ: begin
                    opmode_d  = 7'h25;
                    alumode_d = '0;
                    ce_d      = 4'b1101;
                    valid_d   = 1'b1;
                    rem_d     = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign INSTR_READY              = (state_q == S_IDLE) && !STALL;
    assign OPMODE                   = opmode_q;
    assign ALUMODE                  = alumode_q;
    assign {CEA2, CEB2, CEC, CEM}   = ce_q;
    assign OUT_VALID                = valid_q;
    assign ILLEGAL                  = illegal_q;
    assign BUSY                     = (state_q == S_SEQ);

endmodule

// File: tb/tb_dsp_ctrl_decode.sv
// Bench for dsp_ctrl_decode: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a beat-list reference model.
module tb_dsp_ctrl_decode;

    localparam int unsigned OPC_W = 5;
    localparam int unsigned CNT_W = 4;

    logic             CLK;
    logic             RESET_N;
    logic             INSTR_VALID;
    logic             INSTR_READY;
    logic [OPC_W-1:0] INSTR_OPC;
    logic [CNT_W-1:0] INSTR_CNT;
    logic             STALL;
    logic [6:0]       OPMODE;
    logic [3:0]       ALUMODE;
    logic             CEA2, CEB2, CEC, CEM;
    logic             OUT_VALID;
    logic             ILLEGAL;
    logic             BUSY;

    dsp_ctrl_decode #(.OPC_W(OPC_W), .CNT_W(CNT_W)) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .INSTR_VALID(INSTR_VALID),
        .INSTR_READY(INSTR_READY),
        .INSTR_OPC  (INSTR_OPC),
        .INSTR_CNT  (INSTR_CNT),
        .STALL      (STALL),
        .OPMODE     (OPMODE),
        .ALUMODE    (ALUMODE),
        .CEA2       (CEA2),
        .CEB2       (CEB2),
        .CEC        (CEC),
        .CEM        (CEM),
        .OUT_VALID  (OUT_VALID),
        .ILLEGAL    (ILLEGAL),
        .BUSY       (BUSY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_chk = 0;
    int n_err = 0;
    logic mon_en = 1'b0;

    // Reference model: current expected word plus the number of MAC beats still owed.
    logic [6:0] m_op;
    logic [3:0] m_alu;
    logic [3:0] m_ce;
    logic       m_valid;
    logic       m_ill;
    int         m_pend;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_set(input logic [6:0] op, input logic [3:0] alu, input logic [3:0] ce,
                         input logic v);
        m_op    = op;
        m_alu   = alu;
        m_ce    = ce;
        m_valid = v;
    endtask

    task automatic model_clear();
        m_set(7'h00, 4'h0, 4'h0, 1'b0);
        m_ill  = 1'b0;
        m_pend = 0;
    endtask

    // Called just after a rising edge, with the inputs the DUT sampled at that edge.
    task automatic model_edge();
        if (!RESET_N) begin
            model_clear();
        end else if (STALL) begin
            m_ill = 1'b0;
        end else begin
            m_ill = 1'b0;
            if (m_pend > 0) begin
                m_set(7'h25, 4'h0, 4'b1101, 1'b1);
                m_pend--;
            end else if (INSTR_VALID) begin
                case (INSTR_OPC)
                    5'd0: m_set(7'h00, 4'h0, 4'h0, 1'b0);
                    5'd1: m_set(7'h33, 4'h0, 4'b1110, 1'b1);
                    5'd2: m_set(7'h33, 4'h3, 4'b1110, 1'b1);
                    5'd3: m_set(7'h05, 4'h0, 4'b1101, 1'b1);
                    5'd4: m_set(7'h25, 4'h0, 4'b1101, 1'b1);
                    5'd5: begin
                        m_set(7'h05, 4'h0, 4'b1101, 1'b1);
                        m_pend = (INSTR_CNT == 0) ? 0 : int'(INSTR_CNT) - 1;
                    end
                    default: begin
                        m_set(7'h00, 4'h0, 4'h0, 1'b0);
                        m_ill = 1'b1;
                    end
                endcase
            end else begin
                m_set(7'h00, 4'h0, 4'h0, 1'b0);
            end
        end
    endtask

    always @(negedge CLK) begin
        if (mon_en) begin
            chk("opmode",  32'(OPMODE),    32'(m_op));
            chk("alumode", 32'(ALUMODE),   32'(m_alu));
            chk("ce",      32'({CEA2, CEB2, CEC, CEM}), 32'(m_ce));
            chk("valid",   32'(OUT_VALID), 32'(m_valid));
            chk("illegal", 32'(ILLEGAL),   32'(m_ill));
            chk("busy",    32'(BUSY),      32'(m_pend > 0));
            chk("ready",   32'(INSTR_READY), 32'((m_pend == 0) && !STALL));
        end
    end

    task automatic cyc(input logic v, input logic [4:0] opc, input logic [3:0] cnt,
                       input logic st);
        INSTR_VALID = v;
        INSTR_OPC   = opc;
        INSTR_CNT   = cnt;
        STALL       = st;
        @(posedge CLK);
        model_edge();
        #2;
    endtask

    task automatic async_reset();
        RESET_N = 1'b0;
        model_clear();
        #1;
        chk("rst_opmode", 32'(OPMODE), 32'h00);
        chk("rst_valid",  32'(OUT_VALID), 32'h0);
        chk("rst_ce",     32'({CEA2, CEB2, CEC, CEM}), 32'h0);
        chk("rst_busy",   32'(BUSY), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int busy_n;
        int rdy_low;
        int beats;
        RESET_N     = 1'b0;
        INSTR_VALID = 1'b0;
        INSTR_OPC   = '0;
        INSTR_CNT   = '0;
        STALL       = 1'b0;
        model_clear();
        repeat (2) @(posedge CLK);
        #2;
        RESET_N = 1'b1;
        mon_en  = 1'b1;

        // Idle after reset release
        cyc(1'b0, 5'd0, 4'd0, 1'b0);
        chk("idle_opmode", 32'(OPMODE), 32'h00);
        chk("idle_valid",  32'(OUT_VALID), 32'h0);
        chk("idle_ready",  32'(INSTR_READY), 32'h1);

        // Async reset with nonzero outputs, no clock edge
        cyc(1'b1, 5'd1, 4'd0, 1'b0);
        chk("pre_rst_opmode", 32'(OPMODE), 32'h33);
        async_reset();
        cyc(1'b0, 5'd0, 4'd0, 1'b0);
        RESET_N = 1'b1;
        cyc(1'b0, 5'd0, 4'd0, 1'b0);
        chk("post_rst_opmode", 32'(OPMODE), 32'h00);
        chk("post_rst_ready",  32'(INSTR_READY), 32'h1);

        // ADD then SUB back-to-back
        cyc(1'b1, 5'd1, 4'd0, 1'b0);
        chk("add_opmode", 32'(OPMODE), 32'h33);
        chk("add_alu",    32'(ALUMODE), 32'h0);
        chk("add_ce",     32'({CEA2, CEB2, CEC, CEM}), 32'b1110);
        chk("add_valid",  32'(OUT_VALID), 32'h1);
        cyc(1'b1, 5'd2, 4'd0, 1'b0);
        chk("sub_alu",    32'(ALUMODE), 32'b0011);
        chk("sub_valid",  32'(OUT_VALID), 32'h1);

        // MACN N=4 followed by MUL
        busy_n  = 0;
        rdy_low = 0;
        cyc(1'b1, 5'd5, 4'd4, 1'b0);
        chk("macn4_b0", 32'(OPMODE), 32'h05);
        busy_n  += int'(BUSY);
        rdy_low += int'(!INSTR_READY);
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b1, 5'd3, 4'd0, 1'b0);
            chk("macn4_bn", 32'(OPMODE), 32'h25);
            busy_n  += int'(BUSY);
            rdy_low += int'(!INSTR_READY);
        end
        cyc(1'b1, 5'd3, 4'd0, 1'b0);
        chk("mul_opmode", 32'(OPMODE), 32'h05);
        chk("mul_ce",     32'({CEA2, CEB2, CEC, CEM}), 32'b1101);
        chk("macn4_busy_cycles",  32'(busy_n), 32'd3);
        chk("macn4_ready_low",    32'(rdy_low), 32'd3);
        cyc(1'b0, 5'd0, 4'd0, 1'b0);

        // MACN N=3 with a 2-cycle stall after beat1, MUL waiting
        beats = 0;
        cyc(1'b1, 5'd5, 4'd3, 1'b0);
        chk("macn3_b0", 32'(OPMODE), 32'h05);
        beats += int'(OUT_VALID);
        cyc(1'b1, 5'd3, 4'd0, 1'b0);
        chk("macn3_b1", 32'(OPMODE), 32'h25);
        beats += int'(OUT_VALID);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 5'd3, 4'd0, 1'b1);
            chk("stall_hold", 32'(OPMODE), 32'h25);
            chk("stall_ready", 32'(INSTR_READY), 32'h0);
        end
        cyc(1'b1, 5'd3, 4'd0, 1'b0);
        chk("macn3_b2", 32'(OPMODE), 32'h25);
        beats += int'(OUT_VALID);
        chk("macn3_beats", 32'(beats), 32'd3);
        cyc(1'b1, 5'd3, 4'd0, 1'b0);
        chk("stall_mul", 32'(OPMODE), 32'h05);
        chk("stall_mul_busy", 32'(BUSY), 32'h0);

        // Illegal opcode, then ADD
        cyc(1'b1, 5'h1F, 4'd0, 1'b0);
        chk("ill_pulse",  32'(ILLEGAL), 32'h1);
        chk("ill_opmode", 32'(OPMODE), 32'h00);
        chk("ill_valid",  32'(OUT_VALID), 32'h0);
        cyc(1'b1, 5'd1, 4'd0, 1'b0);
        chk("ill_clear",  32'(ILLEGAL), 32'h0);
        chk("ill_add",    32'(OPMODE), 32'h33);

        // Reset during beat 2 of MACN N=8
        cyc(1'b1, 5'd5, 4'd8, 1'b0);
        cyc(1'b0, 5'd0, 4'd0, 1'b0);
        cyc(1'b0, 5'd0, 4'd0, 1'b0);
        chk("macn8_b2", 32'(OPMODE), 32'h25);
        async_reset();
        cyc(1'b0, 5'd0, 4'd0, 1'b0);
        RESET_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 5'd0, 4'd0, 1'b0);
            chk("abort_opmode", 32'(OPMODE), 32'h00);
            chk("abort_valid",  32'(OUT_VALID), 32'h0);
        end

        // MACN with N=0 and N=1
        for (int c = 0; c < 2; c++) begin
            cyc(1'b1, 5'd5, 4'(c), 1'b0);
            chk("macn_small_op",   32'(OPMODE), 32'h05);
            chk("macn_small_busy", 32'(BUSY), 32'h0);
            cyc(1'b0, 5'd0, 4'd0, 1'b0);
            chk("macn_small_next", 32'(OUT_VALID), 32'h0);
        end

        // MACN with maximum count
        beats = 0;
        cyc(1'b1, 5'd5, 4'd15, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 5'd0, 4'd0, 1'b0);
            if (OUT_VALID && OPMODE == 7'h25) beats++;
        end
        chk("macn15_tail_beats", 32'(beats), 32'd14);

        // Randomized traffic, checked by the per-cycle monitor
        for (int i = 0; i < 600; i++) begin
            logic       v;
            logic [4:0] opc;
            logic [3:0] cnt;
            logic       st;
            int unsigned r;
            v   = ($urandom_range(0, 3) != 0);
            r   = $urandom_range(0, 9);
            opc = (r <= 5) ? 5'(r) : 5'($urandom_range(6, 31));
            cnt = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            st  = ($urandom_range(0, 3) == 0);
            cyc(v, opc, cnt, st);
        end
        cyc(1'b0, 5'd0, 4'd0, 1'b0);
        @(negedge CLK);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
